// File: rtl/bottle_batch_downcounter.sv
// bottle_batch_downcounter: loads a batch size, counts bottles down to zero, waits for ack and tallies batches
module bottle_batch_downcounter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] batch_size,
  input  logic             bottle_in,
  input  logic             ack,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] batches,
  output logic             stray
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state;
  logic s1, s2, s3;
  logic pulse;
  assign pulse = s2 & ~s3;
  assign busy = state == COUNT;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      remaining <= '0;
      batches <= '0;
      stray <= 1'b0;
      {s3, s2, s1} <= 3'b000;
    end else begin
      {s3, s2, s1} <= {s2, s1, bottle_in};
      case (state)
        IDLE:
          if (start) begin
            remaining <= batch_size;
            stray <= 1'b0;
            state <= (batch_size != '0) ? COUNT : DONE;
          end else if (pulse) stray <= 1'b1;
        COUNT:
          if (pulse) begin
            remaining <= remaining - WIDTH'(1);
            if (remaining == WIDTH'(1)) state <= DONE;
          end
        DONE: begin
          if (pulse) stray <= 1'b1;
          if (ack) begin
            batches <= batches + WIDTH'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bottle_batch_downcounter.sv
// tb_bottle_batch_downcounter: vector table, directed corner sequences and random run against a reference model
module tb_bottle_batch_downcounter;
  logic clk = 0, reset = 0, start = 0, bottle_in = 0, ack = 0;
  logic [7:0] batch_size = 0;
  logic [7:0] remaining, batches;
  logic busy, done, stray;
  int tests = 0, fails = 0;

  bottle_batch_downcounter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .batch_size(batch_size),
    .bottle_in(bottle_in), .ack(ack), .remaining(remaining), .busy(busy),
    .done(done), .batches(batches), .stray(stray)
  );

  always #5 clk = ~clk;

  // Reference model: a bottle whose rise is sampled at edge n is counted at edge n+2.
  int m_rem, m_bat, m_phase, ncyc;
  bit m_stray, prev;
  int pend[$];

  task automatic model_step();
    bit pulse;
    ncyc++;
    if (!reset) begin
      m_rem = 0; m_bat = 0; m_stray = 0; m_phase = 0; prev = 0;
      pend.delete();
    end else begin
      pulse = pend.size() > 0 && pend[0] == ncyc;
      if (pulse) void'(pend.pop_front());
      if (bottle_in && !prev) pend.push_back(ncyc + 2);
      prev = bottle_in;
      if (m_phase == 0) begin
        if (start) begin
          m_rem = int'(batch_size);
          m_stray = 0;
          m_phase = batch_size != 0 ? 1 : 2;
        end else if (pulse) m_stray = 1;
      end else if (m_phase == 1) begin
        if (pulse) begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end else begin
        if (pulse) m_stray = 1;
        if (ack) begin
          m_bat = (m_bat + 1) % 256;
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic [7:0] sz, input logic b, input logic a);
    reset = r; start = st; batch_size = sz; bottle_in = b; ack = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc_m(input string nm, input logic r, input logic st, input logic [7:0] sz, input logic b, input logic a);
    cyc(r, st, sz, b, a);
    chk(nm, {13'd0, remaining, busy, done, batches, stray},
        {13'd0, 8'(m_rem), m_phase == 1, m_phase == 2, 8'(m_bat), m_stray});
  endtask

  task automatic bottle(input string nm, input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc_m(nm, 1, 0, 8'd0, 1, 0);
    for (int i = 0; i < lo; i++) cyc_m(nm, 1, 0, 8'd0, 0, 0);
  endtask

  typedef struct {
    logic r, st; logic [7:0] sz; logic b, a;
    logic [7:0] rem; logic bu, dn; logic [7:0] bat; logic sy;
  } vec_t;
  vec_t tbl[26];

  function automatic vec_t mk(logic r, st, logic [7:0] sz, logic b, a, logic [7:0] rem, logic bu, dn, logic [7:0] bat, logic sy);
    mk = '{r, st, sz, b, a, rem, bu, dn, bat, sy};
  endfunction

  initial begin
    logic rb;
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 3, 0, 0, 3, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 9, 1, 0, 3, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 9, 1, 0, 3, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 9, 1, 0, 2, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 9, 1, 0, 2, 1, 0, 0, 0);
    for (int i = 6; i < 10; i++) tbl[i] = mk(1, 0, 9, 0, 0, 2, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 9, 1, 0, 2, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 9, 1, 0, 2, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0);
    tbl[13] = mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 14; i < 18; i++) tbl[i] = mk(1, 0, 9, 0, 0, 1, 1, 0, 0, 0);
    tbl[18] = mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0);
    tbl[19] = mk(1, 0, 9, 1, 0, 1, 1, 0, 0, 0);
    tbl[20] = mk(1, 0, 9, 1, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(1, 0, 9, 1, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(1, 0, 9, 0, 1, 0, 0, 0, 1, 0);
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[24] = mk(1, 0, 0, 0, 1, 0, 0, 0, 2, 0);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].r, tbl[i].st, tbl[i].sz, tbl[i].b, tbl[i].a);
      chk($sformatf("vec%0d", i), {13'd0, remaining, busy, done, batches, stray},
          {13'd0, tbl[i].rem, tbl[i].bu, tbl[i].dn, tbl[i].bat, tbl[i].sy});
    end

    bottle("idle_stray", 4, 4);
    chk("idle_stray_set", 32'(stray), 32'd1);
    cyc_m("start2", 1, 1, 8'd2, 0, 0);
    chk("start_clears_stray", {30'd0, stray, busy}, 32'b01);
    bottle("cnt2", 4, 4);
    bottle("cnt2", 4, 4);
    chk("done_after_2", {30'd0, done, busy}, 32'b10);
    bottle("done_stray", 4, 4);
    chk("done_stray_set", 32'(stray), 32'd1);
    cyc_m("ack3", 1, 0, 8'd0, 0, 1);

    cyc_m("start5", 1, 1, 8'd5, 0, 0);
    bottle("cnt5", 4, 4);
    bottle("cnt5", 4, 4);
    chk("rem_3", 32'(remaining), 32'd3);
    cyc_m("inflight", 1, 0, 8'd0, 1, 0);
    cyc_m("mid_reset", 0, 0, 8'd0, 1, 0);
    chk("mid_reset_out", {8'd0, remaining, busy, done, batches, 6'd0}, 32'd0);
    for (int i = 0; i < 4; i++) cyc_m("post_reset", 1, 0, 8'd0, 0, 0);
    chk("no_inflight_dec", {22'd0, remaining, busy, stray}, 32'd0);

    for (int k = 0; k < 256; k++) begin
      cyc_m("wrap_start", 1, 1, 8'd1, 0, 0);
      cyc_m("wrap_b", 1, 0, 8'd0, 1, 0);
      for (int i = 0; i < 3; i++) cyc_m("wrap_w", 1, 0, 8'd0, 0, 0);
      if (k == 255) begin
        chk("bat_255", {23'd0, batches, done}, {23'd0, 8'd255, 1'b1});
        cyc_m("start_ack", 1, 1, 8'd1, 0, 1);
        chk("wrap_zero", {13'd0, remaining, busy, done, batches, stray}, 32'd0);
      end else cyc_m("wrap_ack", 1, 0, 8'd0, 0, 1);
    end
    cyc_m("start_later", 1, 1, 8'd1, 0, 0);
    chk("start_later_busy", 32'(busy), 32'd1);

    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 3 == 0) rb = ~rb;
      cyc_m("rand", ($urandom % 64) != 0, ($urandom % 4) == 0, 8'($urandom % 4), rb, ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
